period_meas_ctrl: RTL and testbench

Fully synchronous sequencer for the RF period-measurement path. It synchronizes the RF input into the `clk` domain and gates a clock-count window over M signal periods. It applies the ±MIN_CHANGE jitter filter and handles loss-of-signal timeout. Downstream frequency-bin and state-firing logic consume the filtered count `n_clk_out` through a one-cycle update strobe.

---
 rtl/qcm_meas_pkg.sv | 15 +
 rtl/sig_sync_edge.sv | 38 +++
 rtl/period_meas_ctrl.sv | 158 +++++++++++++++
 tb/tb_period_meas_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qcm_meas_pkg.sv
// Shared defaults and state encoding for the RF period-measurement path.
package qcm_meas_pkg;

  localparam int unsigned M_DEF          = 50;
  localparam int unsigned CNT_W_DEF      = 14;
  localparam int unsigned SIG_W_DEF      = 7;
  localparam int unsigned MIN_CHANGE_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2
  } meas_state_e;

endpackage

// File: rtl/sig_sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// rising-edge pulse; the pulse appears 3 clk cycles after the input rises.
module sig_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic sig_edge
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic sync_dly_q, sync_dly_d;
  logic edge_q, edge_d;

  always_comb begin
    meta_d     = sig_in;
    sync_d     = meta_q;
    sync_dly_d = sync_q;
    edge_d     = sync_q & ~sync_dly_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      sync_dly_q <= 1'b0;
      edge_q     <= 1'b0;
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      sync_dly_q <= sync_dly_d;
      edge_q     <= edge_d;
    end
  end

  assign sig_edge = edge_q;

endmodule

// File: rtl/period_meas_ctrl.sv
// Counts clk cycles across M consecutive sig periods, filters small changes
// in the result and flags loss of signal when the count ceiling is reached.
module period_meas_ctrl
  import qcm_meas_pkg::*;
#(
  parameter int unsigned M          = M_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned SIG_W      = SIG_W_DEF,
  parameter int unsigned MIN_CHANGE = MIN_CHANGE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sig,
  output logic [CNT_W-1:0]  n_clk_out,
  output logic              upd,
  output logic              meas_valid,
  output logic [CNT_W-1:0]  n_clk_raw,
  output logic              timeout,
  output logic              busy,
  output meas_state_e       state_dbg
);

  // Strobes carry no back-pressure: meas_valid marks a new n_clk_raw for
  // exactly one cycle, and upd (only ever alongside meas_valid) marks a new
  // n_clk_out. Consumers must take the values in that cycle.

  // Last counter value that can still complete a window without overflow.
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [SIG_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] raw_q, raw_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic             has_upd_q, has_upd_d;
  logic             timeout_q, timeout_d;
  logic             upd_q, upd_d;
  logic             meas_valid_q, meas_valid_d;

  logic             edge_pulse;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] delta;
  logic             big_change;
  logic             terminal;

  sig_sync_edge u_sig_sync (
    .clk      (clk),
    .reset    (reset),
    .sig_in   (sig),
    .sig_edge (edge_pulse)
  );

  // Distance to the last published value, ordered first so it never wraps.
  always_comb begin
    cnt_inc = clk_cnt_q + CNT_W'(1);
    if (cnt_inc >= out_q) begin
      delta = cnt_inc - out_q;
    end else begin
      delta = out_q - cnt_inc;
    end
    big_change = delta > CNT_W'(MIN_CHANGE);
    terminal   = edge_pulse && (edge_cnt_q == SIG_W'(M - 1));
  end

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    raw_d        = raw_q;
    out_d        = out_q;
    has_upd_d    = has_upd_q;
    timeout_d    = timeout_q;
    upd_d        = 1'b0;
    meas_valid_d = 1'b0;
    if (!en) begin
      state_d    = ST_IDLE;
      clk_cnt_d  = '0;
      edge_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          clk_cnt_d  = '0;
          edge_cnt_d = '0;
          state_d    = ST_ARM;
        end
        ST_ARM: begin
          if (edge_pulse) begin
            clk_cnt_d  = '0;
            edge_cnt_d = '0;
            state_d    = ST_COUNT;
          end
        end
        ST_COUNT: begin
          clk_cnt_d = cnt_inc;
          if (edge_pulse) begin
            edge_cnt_d = edge_cnt_q + SIG_W'(1);
          end
          // The terminating edge also opens the next window, so both
          // counters restart without leaving COUNT.
          if (terminal) begin
            raw_d        = cnt_inc;
            meas_valid_d = 1'b1;
            timeout_d    = 1'b0;
            clk_cnt_d    = '0;
            edge_cnt_d   = '0;
            if (!has_upd_q || big_change) begin
              out_d     = cnt_inc;
              has_upd_d = 1'b1;
              upd_d     = 1'b1;
            end
          end else if (clk_cnt_q == CNT_LAST) begin
            timeout_d  = 1'b1;
            clk_cnt_d  = '0;
            edge_cnt_d = '0;
            state_d    = ST_ARM;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      clk_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      raw_q        <= '0;
      out_q        <= '0;
      has_upd_q    <= 1'b0;
      timeout_q    <= 1'b0;
      upd_q        <= 1'b0;
      meas_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      raw_q        <= raw_d;
      out_q        <= out_d;
      has_upd_q    <= has_upd_d;
      timeout_q    <= timeout_d;
      upd_q        <= upd_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  assign n_clk_out  = out_q;
  assign n_clk_raw  = raw_q;
  assign upd        = upd_q;
  assign meas_valid = meas_valid_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q != ST_IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_period_meas_ctrl.sv
// Bench for period_meas_ctrl: event-level reference model compared every
// cycle, plus a capture scoreboard loaded with hand-computed windows.
module tb_period_meas_ctrl;
  import qcm_meas_pkg::*;

  localparam int M          = 50;
  localparam int CNT_W      = 14;
  localparam int MIN_CHANGE = 2;
  localparam int MAX_CNT    = (1 << CNT_W) - 1;
  localparam int CW         = 2 * CNT_W + 1;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             sig;
  logic [CNT_W-1:0] n_clk_out;
  logic [CNT_W-1:0] n_clk_raw;
  logic             upd;
  logic             meas_valid;
  logic             timeout;
  logic             busy;
  meas_state_e      state_dbg;

  initial forever #5 clk = ~clk;

  period_meas_ctrl #(
    .M          (M),
    .CNT_W      (CNT_W),
    .SIG_W      (7),
    .MIN_CHANGE (MIN_CHANGE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .sig        (sig),
    .n_clk_out  (n_clk_out),
    .upd        (upd),
    .meas_valid (meas_valid),
    .n_clk_raw  (n_clk_raw),
    .timeout    (timeout),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int abs_diff(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // ---------------- reference model ----------------
  // Works on edge arrival times: an edge reaches the sequencer 3 cycles
  // after the sig rise is first sampled, and a window's count is simply the
  // number of cycles between its first and last edge.
  int cyc;
  bit m_prev, m_p0, m_p1, m_p2, m_edge, m_rise;
  bit m_active, m_counting;
  int m_start, m_edges;
  bit m_has, m_upd, m_mv, m_to;
  int m_out, m_raw;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_prev = 0; m_p0 = 0; m_p1 = 0; m_p2 = 0;
      m_active = 0; m_counting = 0; m_start = 0; m_edges = 0;
      m_has = 0; m_upd = 0; m_mv = 0; m_to = 0; m_out = 0; m_raw = 0;
    end else begin
      cyc++;
      m_edge = m_p2;
      m_rise = (sig === 1'b1) && !m_prev;
      m_p2 = m_p1; m_p1 = m_p0; m_p0 = m_rise; m_prev = (sig === 1'b1);
      m_upd = 0;
      m_mv  = 0;
      if (!en) begin
        m_active   = 0;
        m_counting = 0;
      end else if (!m_active) begin
        m_active = 1;
      end else if (!m_counting) begin
        if (m_edge) begin
          m_counting = 1;
          m_start    = cyc;
          m_edges    = 0;
        end
      end else begin
        if (m_edge) m_edges++;
        if (m_edge && m_edges == M) begin
          m_raw   = cyc - m_start;
          m_mv    = 1;
          m_to    = 0;
          m_start = cyc;
          m_edges = 0;
          if (!m_has || abs_diff(m_raw, m_out) > MIN_CHANGE) begin
            m_out = m_raw;
            m_has = 1;
            m_upd = 1;
          end
        end else if (cyc - m_start == MAX_CNT) begin
          m_to       = 1;
          m_counting = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (reset === 1'b0) begin
      check_val("n_clk_out", n_clk_out, m_out);
      check_val("n_clk_raw", n_clk_raw, m_raw);
      check_val("upd", upd, m_upd);
      check_val("meas_valid", meas_valid, m_mv);
      check_val("timeout", timeout, m_to);
      check_val("busy", busy, m_active);
    end
  end

  // ---------------- capture scoreboard ----------------
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] sb_e;
  bit            sb_on = 0;

  function automatic void expect_cap(input int raw, input bit u, input int out);
    exp_q.push_back({u, CNT_W'(out), CNT_W'(raw)});
  endfunction

  initial forever begin
    @(negedge clk);
    if (reset === 1'b0 && sb_on && meas_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL capture: unexpected window raw %0d out %0d upd %0b", n_clk_raw, n_clk_out, upd);
      end else begin
        sb_e = exp_q.pop_front();
        if ({upd, n_clk_out, n_clk_raw} !== sb_e) begin
          errors++;
          $display("FAIL capture: got raw %0d out %0d upd %0b expected raw %0d out %0d upd %0b",
                   n_clk_raw, n_clk_out, upd,
                   sb_e[CNT_W-1:0], sb_e[2*CNT_W-1:CNT_W], sb_e[2*CNT_W]);
        end
      end
    end
  end

  task automatic check_drained(input string name);
    check_val(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  // One call = one sig rise followed by p cycles until the next rise.
  task automatic run_period(input int p);
    int hi;
    hi = p / 2;
    sig = 1'b1;
    repeat (hi) @(negedge clk);
    sig = 1'b0;
    repeat (p - hi) @(negedge clk);
  endtask

  task automatic send_window(input int base, input int last_p);
    repeat (M - 1) run_period(base);
    run_period(last_p);
  endtask

  int g_base;
  int g_p;

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    en    = 1'b0;
    sig   = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_n_clk_out", n_clk_out, 0);
    check_val("rst_n_clk_raw", n_clk_raw, 0);
    check_val("rst_upd", upd, 0);
    check_val("rst_meas_valid", meas_valid, 0);
    check_val("rst_timeout", timeout, 0);
    check_val("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_val("idle_busy", busy, 0);

    // Steady period 80: first window publishes, second is filtered.
    sb_on = 1;
    en    = 1'b1;
    expect_cap(4000, 1, 4000);
    expect_cap(4000, 0, 4000);
    send_window(80, 80);
    send_window(80, 80);
    repeat (20) run_period(80);
    check_drained("period80_caps");
    check_val("model_out_80", m_out, 4000);

    // Reset mid-window, then jitter inside and outside the filter band.
    reset = 1'b1;
    #1;
    check_val("midrst_n_clk_out", n_clk_out, 0);
    check_val("midrst_n_clk_raw", n_clk_raw, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_timeout", timeout, 0);
    @(negedge clk);
    reset = 1'b0;
    expect_cap(4000, 1, 4000);
    expect_cap(4002, 0, 4000);
    expect_cap(3998, 0, 4000);
    expect_cap(4003, 1, 4003);
    send_window(80, 80);
    send_window(80, 82);
    send_window(80, 78);
    send_window(80, 83);
    run_period(80);

    // Sig stops: loss-of-signal.
    repeat (16400) @(negedge clk);
    check_drained("jitter_caps");
    check_val("timeout_set", timeout, 1);
    check_val("timeout_state_arm", state_dbg, ST_ARM);
    check_val("timeout_out_held", n_clk_out, 4003);
    check_val("model_timeout", m_to, 1);

    // Resume at period 13.
    expect_cap(650, 1, 650);
    send_window(13, 13);
    run_period(13);
    check_drained("resume_caps");
    check_val("timeout_cleared", timeout, 0);

    // en dropped after 20 edges, then a fresh full window.
    repeat (19) run_period(20);
    en = 1'b0;
    @(negedge clk);
    check_val("busy_en_low", busy, 0);
    repeat (30) run_period(20);
    en = 1'b1;
    expect_cap(1000, 1, 1000);
    expect_cap(16383, 1, 16383);
    send_window(20, 20);
    // Terminating edge lands exactly on the count ceiling.
    send_window(327, 360);
    run_period(30);
    check_drained("ceiling_caps");
    check_val("ceiling_timeout", timeout, 0);
    check_val("model_raw_ceiling", m_raw, 16383);

    // Randomized windows with occasional en glitches.
    sb_on = 0;
    for (int w = 0; w < 8; w++) begin
      g_base = $urandom_range(2, 40);
      for (int i = 0; i < M; i++) begin
        g_p = g_base + $urandom_range(0, 3);
        if ($urandom_range(0, 149) == 0) begin
          en = 1'b0;
          repeat ($urandom_range(1, 5)) @(negedge clk);
          en = 1'b1;
        end
        run_period(g_p);
      end
    end
    en = 1'b0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
